cache_miss_sequencer: RTL
=========================

# cache_miss_sequencer

Miss-handling controller for the cache core. On a miss reported by the lookup stage, it writes the dirty victim line back to backing memory word by word, then refills the missing line from memory into the cache data array, and signals completion. It is the only block that drives the backing-memory port and the cache array's refill write port.

## Interface
- ADDR_W, 8, byte/word address width on the memory port
- DATA_W, 8, word width
- OFF_W, 2, word-offset bits; line = 2^OFF_W words; line address width LA_W = ADDR_W-OFF_W

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- miss_valid  in  1  miss request from lookup stage
- miss_ready  out  1  high only in IDLE; request accepted when miss_valid & miss_ready at a rising edge
- miss_line  in  LA_W  line address to fetch, sampled at accept
- miss_dirty  in  1  victim line needs write-back, sampled at accept
- victim_line  in  LA_W  victim line address, sampled at accept
- victim_word  out  OFF_W  word index driving cache array read port
- victim_rdata  in  DATA_W  combinational array read data for victim_word
- fill_we  out  1  cache array write strobe (registered)
- fill_word  out  OFF_W  word index for fill write
- fill_data  out  DATA_W  data for fill write
- done  out  1  one-cycle completion pulse
- busy  out  1  high whenever state is not IDLE
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write (write-back), 0 = read (refill)
- mem_addr  out  ADDR_W  {line, word counter}
- mem_wdata  out  DATA_W  write data, equals victim_rdata
- mem_ack  in  1  transfer completes in the cycle mem_req & mem_ack are both high
- mem_rdata  in  DATA_W  read data, valid with mem_ack during reads

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE: miss_ready=1. On accept, latch miss_line, victim_line, miss_dirty; clear word counter; go to WB if dirty else FILL.
- WB: mem_req=1, mem_we=1, mem_addr={victim_line_q, cnt}, victim_word=cnt, mem_wdata=victim_rdata. On ack: cnt+1; on ack with cnt=2^OFF_W-1, cnt wraps to 0, go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={miss_line_q, cnt}. On ack: register fill_we<=1, fill_word<=cnt, fill_data<=mem_rdata; cnt+1; on last word go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- fill_we is 0 in every cycle not directly following a FILL ack.
- victim_word = cnt in all states (only meaningful in WB).
- Counter is OFF_W bits and wraps naturally; no overflow state.

## Timing
- Reset: state IDLE, cnt 0, miss_ready 1, busy 0, done 0, fill_we 0, fill_word 0, fill_data 0, mem_req 0, mem_we 0, mem_addr 0, latched addresses 0.
- Request accepted at edge T0 → mem_req first high in cycle T1.
- mem_ack held low: mem_req, mem_we, mem_addr, mem_wdata hold stable; no counter advance.
- mem_ack while mem_req=0 is ignored.
- Clean miss, ack every cycle (4-word line): reads T1–T4, fill_we T2–T5, done T5 (coincides with last fill_we), miss_ready high T6.
- Dirty miss, ack every cycle: writes T1–T4, reads T5–T8, done T9, miss_ready T10; no idle cycle between WB and FILL.
- miss_valid outside IDLE is ignored; no queueing.
- rst mid-operation: next cycle all outputs at reset values; transfer abandoned, no done pulse, no further fill_we.

## Test plan
- Clean miss: miss_line=0x05, miss_dirty=0, ack every cycle, mem_rdata=0xA0+word → mem_addr 0x14,0x15,0x16,0x17 with mem_we=0; fill_we T2–T5 with words 0–3, data 0xA0–0xA3; done only at T5.
- Dirty miss: victim_line=0x3C, miss_line=0x02, victim_rdata=0x50+victim_word → writes to 0xF0–0xF3 with data 0x50–0x53, then reads 0x08–0x0B; done at T9.
- Stalled memory: ack only every third cycle during FILL → mem_addr stable across stall cycles, exactly 4 fill_we pulses, done one cycle after last ack.
- Ignored requests: miss_valid held high with new miss_line throughout an active miss → only the first request served; miss_ready=0 until DONE passes; second request accepted in the cycle after done.
- Reset mid-WB: assert rst after 2nd write ack → next cycle mem_req=0, busy=0, miss_ready=1, no done or fill_we; a fresh clean miss afterwards completes normally starting at word 0.

Source files
------------

// File: rtl/cache_miss_sequencer.sv
// Miss-handling controller: writes back a dirty victim line, refills the
// missing line from backing memory into the cache array, then pulses done.
module cache_miss_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int OFF_W  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      miss_valid,
   output logic                      miss_ready,
   input  logic [ADDR_W-OFF_W-1:0]   miss_line,
   input  logic                      miss_dirty,
   input  logic [ADDR_W-OFF_W-1:0]   victim_line,
   output logic [OFF_W-1:0]          victim_word,
   input  logic [DATA_W-1:0]         victim_rdata,
   output logic                      fill_we,
   output logic [OFF_W-1:0]          fill_word,
   output logic [DATA_W-1:0]         fill_data,
   output logic                      done,
   output logic                      busy,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_ack,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int LA_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {
      IDLE,
      WB,
      FILL,
      DONE
   } state_t;

   state_t            state, state_nxt;
   logic [OFF_W-1:0]  cnt, cnt_nxt;
   logic [LA_W-1:0]   miss_line_q;
   logic [LA_W-1:0]   victim_line_q;
   logic              accept;
   logic              last_word;
   logic              fill_ack;

   assign accept      = (state == IDLE) && miss_valid;
   assign last_word   = (cnt == '1);
   assign fill_ack    = (state == FILL) && mem_ack;
   assign victim_word = cnt;
   assign mem_wdata   = victim_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         miss_line_q   <= '0;
         victim_line_q <= '0;
         fill_we       <= 1'b0;
         fill_word     <= '0;
         fill_data     <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         fill_we <= fill_ack;
         if (accept) begin
            miss_line_q   <= miss_line;
            victim_line_q <= victim_line;
         end
         // Fill strobe trails the memory ack by one cycle; word/data hold otherwise.
         if (fill_ack) begin
            fill_word <= cnt;
            fill_data <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      miss_ready = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      case (state)
         IDLE: begin
            miss_ready = 1'b1;
            busy       = 1'b0;
            if (miss_valid) begin
               cnt_nxt   = '0;
               state_nxt = miss_dirty ? WB : FILL;
            end
         end
         WB: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {victim_line_q, cnt};
            if (mem_ack) begin
               cnt_nxt = cnt + 1'b1;
               if (last_word) state_nxt = FILL;
            end
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {miss_line_q, cnt};
            if (mem_ack) begin
               cnt_nxt = cnt + 1'b1;
               if (last_word) state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
